// File: rtl/cpu_trace_checker_pkg.sv
// Shared definitions for the CPU trace line checker.
// Contents: FSM state codes, ASCII constants for the trace syntax,
// format_type codes, error_code bit positions and an address window helper.
package cpu_trace_checker_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TIME,
    ST_PC,
    ST_SP1,
    ST_GRF,
    ST_ADDR,
    ST_SP2,
    ST_LT,
    ST_SP3,
    ST_DATA,
    ST_ACCEPT
  } state_e;

  localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT     = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam int ERR_PC   = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_GRF  = 2;

  // Register numbers are accumulated in a fixed 14-bit register.
  localparam int GRF_ACC_W = 14;
  localparam logic [GRF_ACC_W-1:0] GRF_LAST = 14'd31;

  // Unsigned window test without separate lo/hi compares: v-lo wraps to a
  // huge value when v<lo, so one compare covers both bounds (needs hi>=lo).
  function automatic logic in_window(input logic [63:0] v,
                                     input logic [63:0] lo,
                                     input logic [63:0] hi);
    return (v - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/cpu_trace_checker_char_digit_decode.sv
// Combinational ASCII digit classifier.
// Ports:
//   i_char   : ASCII character
//   o_is_dec : '0'-'9'
//   o_is_hex : '0'-'9', 'a'-'f', plus 'A'-'F' when UPPER_OK=1
//   o_nibble : value of the digit (0 when not a hex digit)
module cpu_trace_checker_char_digit_decode #(
  parameter bit UPPER_OK = 1'b0
) (
  input  logic [7:0] i_char,
  output logic       o_is_dec,
  output logic       o_is_hex,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_is_dec = 1'b0;
    o_is_hex = 1'b0;
    o_nibble = 4'd0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      o_is_dec = 1'b1;
      o_is_hex = 1'b1;
      o_nibble = 4'(i_char - 8'h30);
    end else if (i_char >= 8'h61 && i_char <= 8'h66) begin
      o_is_hex = 1'b1;
      o_nibble = 4'(i_char - 8'h57);
    end else if (UPPER_OK && i_char >= 8'h41 && i_char <= 8'h46) begin
      o_is_hex = 1'b1;
      o_nibble = 4'(i_char - 8'h37);
    end
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// Character-stream checker for CPU trace lines, one ASCII char per clock.
// Recognises "^<time>@<pc>: $<grf> <= <data>#" and
// "^<time>@<pc>: *<addr> <= <data>#", captures the fields and flags
// out-of-window / misaligned values.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_char          : ASCII character sampled every posedge
//   o_format_type   : 00 none, 01 register line, 10 memory line
//   o_error_code    : [0] pc, [1] addr, [2] grf error
//   o_time_val      : decimal time value
//   o_pc_val        : pc field
//   o_dest_val      : grf number (zero-extended) or memory address
//   o_data_val      : data field
// All outputs are nonzero only during the single ACCEPT cycle.
//
// state     | meaning
// ----------+-------------------------------------------
// IDLE      | waiting for '^'
// TIME      | decimal time digits, expecting '@'
// PC        | pc hex digits, expecting ':'
// SP1       | spaces, expecting '$' or '*'
// GRF       | register number digits
// ADDR      | memory address hex digits
// SP2       | spaces before '<'
// LT        | '<' seen, '=' must follow immediately
// SP3       | spaces, expecting first data digit
// DATA      | data hex digits, expecting '#'
// ACCEPT    | complete line, outputs valid for one cycle
module cpu_trace_checker
  import cpu_trace_checker_pkg::*;
#(
  parameter int  TIME_MAX_DIGITS = 4,
  parameter int  GRF_MAX_DIGITS  = 4,
  parameter int  HEX_DIGITS      = 8,
  parameter int  TIME_W          = 14,
  parameter bit  UPPER_OK        = 1'b0,
  parameter logic [4*HEX_DIGITS-1:0] PC_LO   = 32'h0000_3000,
  parameter logic [4*HEX_DIGITS-1:0] PC_HI   = 32'h0000_4fff,
  parameter logic [4*HEX_DIGITS-1:0] ADDR_LO = 32'h0000_0000,
  parameter logic [4*HEX_DIGITS-1:0] ADDR_HI = 32'h0000_2fff
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [7:0]              i_char,
  output logic [1:0]              o_format_type,
  output logic [2:0]              o_error_code,
  output logic [TIME_W-1:0]       o_time_val,
  output logic [4*HEX_DIGITS-1:0] o_pc_val,
  output logic [4*HEX_DIGITS-1:0] o_dest_val,
  output logic [4*HEX_DIGITS-1:0] o_data_val
);

  localparam int DW    = 4 * HEX_DIGITS;
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] TIME_MAX = CNT_W'(TIME_MAX_DIGITS);
  localparam logic [CNT_W-1:0] GRF_MAX  = CNT_W'(GRF_MAX_DIGITS);
  localparam logic [CNT_W-1:0] HEX_N    = CNT_W'(HEX_DIGITS);

  state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [TIME_W-1:0]      r_time, w_time_nxt;
  logic [DW-1:0]          r_pc, w_pc_nxt;
  logic [DW-1:0]          r_addr, w_addr_nxt;
  logic [GRF_ACC_W-1:0]   r_grf, w_grf_nxt;
  logic [DW-1:0]          r_data, w_data_nxt;
  logic                   r_is_mem, w_is_mem_nxt;

  logic                   w_is_dec;
  logic                   w_is_hex;
  logic [3:0]             w_nibble;
  logic                   w_accept;
  logic [2:0]             w_err;

  cpu_trace_checker_char_digit_decode #(
    .UPPER_OK (UPPER_OK)
  ) u_digit (
    .i_char   (i_char),
    .o_is_dec (w_is_dec),
    .o_is_hex (w_is_hex),
    .o_nibble (w_nibble)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_time   <= '0;
      r_pc     <= '0;
      r_addr   <= '0;
      r_grf    <= '0;
      r_data   <= '0;
      r_is_mem <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_time   <= w_time_nxt;
      r_pc     <= w_pc_nxt;
      r_addr   <= w_addr_nxt;
      r_grf    <= w_grf_nxt;
      r_data   <= w_data_nxt;
      r_is_mem <= w_is_mem_nxt;
    end
  end

  // Any character not explicitly accepted below (including a digit once the
  // field is full) drops to IDLE, so the counter never has to exceed max.
  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_cnt_nxt    = r_cnt;
    w_time_nxt   = r_time;
    w_pc_nxt     = r_pc;
    w_addr_nxt   = r_addr;
    w_grf_nxt    = r_grf;
    w_data_nxt   = r_data;
    w_is_mem_nxt = r_is_mem;

    if (i_char == CH_CARET) begin
      w_state_nxt  = ST_TIME;
      w_cnt_nxt    = '0;
      w_time_nxt   = '0;
      w_pc_nxt     = '0;
      w_addr_nxt   = '0;
      w_grf_nxt    = '0;
      w_data_nxt   = '0;
      w_is_mem_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_TIME: begin
          if (w_is_dec && r_cnt < TIME_MAX) begin
            w_state_nxt = ST_TIME;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_time_nxt  = r_time * TIME_W'(10) + TIME_W'(w_nibble);
          end else if (i_char == CH_AT && r_cnt != '0) begin
            w_state_nxt = ST_PC;
            w_cnt_nxt   = '0;
          end
        end
        ST_PC: begin
          if (w_is_hex && r_cnt < HEX_N) begin
            w_state_nxt = ST_PC;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_pc_nxt    = {r_pc[DW-5:0], w_nibble};
          end else if (i_char == CH_COLON && r_cnt == HEX_N) begin
            w_state_nxt = ST_SP1;
          end
        end
        ST_SP1: begin
          if (i_char == CH_SPACE) begin
            w_state_nxt = ST_SP1;
          end else if (i_char == CH_DOLLAR) begin
            w_state_nxt  = ST_GRF;
            w_cnt_nxt    = '0;
            w_is_mem_nxt = 1'b0;
          end else if (i_char == CH_STAR) begin
            w_state_nxt  = ST_ADDR;
            w_cnt_nxt    = '0;
            w_is_mem_nxt = 1'b1;
          end
        end
        ST_GRF: begin
          if (w_is_dec && r_cnt < GRF_MAX) begin
            w_state_nxt = ST_GRF;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_grf_nxt   = r_grf * GRF_ACC_W'(10) + GRF_ACC_W'(w_nibble);
          end else if (r_cnt != '0 && i_char == CH_SPACE) begin
            w_state_nxt = ST_SP2;
          end else if (r_cnt != '0 && i_char == CH_LT) begin
            w_state_nxt = ST_LT;
          end
        end
        ST_ADDR: begin
          if (w_is_hex && r_cnt < HEX_N) begin
            w_state_nxt = ST_ADDR;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_addr_nxt  = {r_addr[DW-5:0], w_nibble};
          end else if (r_cnt == HEX_N && i_char == CH_SPACE) begin
            w_state_nxt = ST_SP2;
          end else if (r_cnt == HEX_N && i_char == CH_LT) begin
            w_state_nxt = ST_LT;
          end
        end
        ST_SP2: begin
          if (i_char == CH_SPACE) w_state_nxt = ST_SP2;
          else if (i_char == CH_LT) w_state_nxt = ST_LT;
        end
        ST_LT: begin
          if (i_char == CH_EQ) w_state_nxt = ST_SP3;
        end
        ST_SP3: begin
          if (i_char == CH_SPACE) begin
            w_state_nxt = ST_SP3;
          end else if (w_is_hex) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = CNT_W'(1);
            w_data_nxt  = DW'(w_nibble);
          end
        end
        ST_DATA: begin
          if (w_is_hex && r_cnt < HEX_N) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_data_nxt  = {r_data[DW-5:0], w_nibble};
          end else if (i_char == CH_HASH && r_cnt == HEX_N) begin
            w_state_nxt = ST_ACCEPT;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_accept = (r_state == ST_ACCEPT);

  always_comb begin
    w_err = '0;
    w_err[ERR_PC]   = !in_window(64'(r_pc), 64'(PC_LO), 64'(PC_HI)) || (r_pc[1:0] != 2'b00);
    w_err[ERR_ADDR] = r_is_mem &&
                      (!in_window(64'(r_addr), 64'(ADDR_LO), 64'(ADDR_HI)) || (r_addr[1:0] != 2'b00));
    w_err[ERR_GRF]  = !r_is_mem && (r_grf > GRF_LAST);
  end

  always_comb begin
    o_format_type = FMT_NONE;
    o_error_code  = '0;
    o_time_val    = '0;
    o_pc_val      = '0;
    o_dest_val    = '0;
    o_data_val    = '0;
    if (w_accept) begin
      o_format_type = r_is_mem ? FMT_MEM : FMT_REG;
      o_error_code  = w_err;
      o_time_val    = r_time;
      o_pc_val      = r_pc;
      o_dest_val    = r_is_mem ? r_addr : DW'(r_grf);
      o_data_val    = r_data;
    end
  end

endmodule

// File: doc/cpu_trace_checker.md
Name: cpu_trace_checker

Overview:
- Character-stream checker for CPU trace lines, one ASCII char per clock; successor of the fixed-width trace format checker.
- Accepts register-write lines "^<time>@<pc>: $<grf> <= <data>#" and memory-write lines "^<time>@<pc>: *<addr> <= <data>#".
- Digit counts, hex case and address windows are parametrised; adds field capture and semantic error flags.
- Sits beside the trace monitor in the simulation harness and feeds the scoreboard.

Parameters:
TIME_MAX_DIGITS, 4, max decimal digits of time (min 1)
GRF_MAX_DIGITS, 4, max decimal digits of register number (min 1)
HEX_DIGITS, 8, exact hex digits of pc, addr and data
TIME_W, 14, width of captured time value
UPPER_OK, 0, 1 = 'A'-'F' accepted as hex digits
PC_LO, 32'h0000_3000, lowest legal pc
PC_HI, 32'h0000_4fff, highest legal pc
ADDR_LO, 32'h0000_0000, lowest legal memory address
ADDR_HI, 32'h0000_2fff, highest legal memory address

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
char  in  8  ASCII character, sampled every posedge
format_type  out  2  00 none, 01 register line, 10 memory line
error_code  out  3  [0] pc error, [1] addr error, [2] grf error
time_val  out  TIME_W  decimal value of time field
pc_val  out  4*HEX_DIGITS  pc field
dest_val  out  4*HEX_DIGITS  grf number (zero-extended) or addr
data_val  out  4*HEX_DIGITS  data field

Behaviour:
- Reset: all state and outputs 0, FSM to IDLE. Reset wins over any char in the same cycle, including '#'. Reset mid-line discards the partial line.
- Moore FSM, one transition per posedge on char: IDLE, TIME, PC, SP1, GRF, ADDR, SP2, LT, SP3, DATA, ACCEPT.
- '^' in any state (including ACCEPT): go to TIME and clear all counters and accumulators.
- TIME: digits counted and accumulated as val*10+d, truncated to TIME_W. '@' with 1..TIME_MAX_DIGITS digits goes to PC.
- PC: exactly HEX_DIGITS hex digits, shifted in MSB first. ':' at the exact count goes to SP1.
- SP1: spaces ignored. '$' goes to GRF; '*' goes to ADDR.
- GRF: 1..GRF_MAX_DIGITS decimal digits, accumulated decimally in 14 bits; leading zeros allowed.
- ADDR: exactly HEX_DIGITS hex digits.
- Leaving GRF or ADDR: ' ' goes to SP2; '<' goes to LT.
- SP2: spaces ignored; '<' goes to LT.
- LT: '=' goes to SP3. "<" and "=" must be adjacent.
- SP3: spaces ignored; hex digit goes to DATA, counted as digit 1.
- DATA: '#' at exactly HEX_DIGITS digits goes to ACCEPT.
- Digit counters saturate at max+1. Reaching max+1 forces IDLE on that edge.
- Any other char or wrong count: go to IDLE.
- ACCEPT lasts exactly one cycle. Next char: '^' goes to TIME, anything else goes to IDLE.
- format_type, error_code and the *_val outputs are registered/decoded from state. They are nonzero only while in ACCEPT, i.e. valid the cycle after the '#' edge; 0 in every other state.
- error_code computed from captured fields:
  - [0] = pc<PC_LO or pc>PC_HI or pc[1:0]!=0
  - [1] = memory line and (addr<ADDR_LO or addr>ADDR_HI or addr[1:0]!=0)
  - [2] = register line and grf>31
- error_code is meaningful only with format_type!=0. A line with errors still reports its format_type.
- Hex digits: '0'-'9', 'a'-'f', plus 'A'-'F' only when UPPER_OK=1. Decimal digits: '0'-'9' only.

Decomposition:
- Shared definitions header: FSM state codes, ASCII constants ('^','@',':','$','*','<','=','#',' '), format_type codes, error_code bit indices.
- One sub-module, char_digit_decode: combinational; char plus UPPER_OK in, is_dec, is_hex and 4-bit nibble out. Instantiated once.

Test Plan:
- "^10@00003000: $1 <= 0000000a#" -> cycle after '#': format_type=01, error_code=000, time_val=10, pc_val=0x3000, dest_val=1, data_val=0xa; 00 the next cycle.
- "^2@00003004:*00000008<=00000001#" -> format_type=10, error_code=000, dest_val=0x8.
- "^7@00003002: $32 <= 00000000#" -> format_type=01, error_code=101. "^7@00003000: *00003000 <= 00000000#" -> format_type=10, error_code=010.
- "^12345@00003000: $1 <= 00000000#" -> 00 throughout. Same line with "< =" -> 00. 7-digit pc -> 00. 'A' in data with UPPER_OK=0 -> 00; with UPPER_OK=1 -> 01.
- Restart: "^1@00^3@00003000: $0<=00000000#" -> 01 with time_val=3. Two back-to-back valid lines -> two single-cycle pulses.
- reset asserted on the '#' cycle -> 00 and all outputs 0. Reset mid-DATA, then a full valid line -> accepted normally.
